// File: rtl/tybec_stream_pkg.sv
// Shared definitions for TyBEC stream nodes: FloPoCo exception codes and
// a width helper for counters that must hold the value 0..n inclusive.
package tybec_stream_pkg;

  localparam logic [1:0] EXC_ZERO   = 2'b00;
  localparam logic [1:0] EXC_NORMAL = 2'b01;
  localparam logic [1:0] EXC_INF    = 2'b10;
  localparam logic [1:0] EXC_NAN    = 2'b11;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/FPMult_8_23_8_23_8_23_F400_uid2.sv
// FloPoCo-format single-precision multiplier core, STAGES-deep pipeline,
// round-to-nearest-even, no subnormals (underflow flushes to zero).
module FPMult_8_23_8_23_8_23_F400_uid2
  import tybec_stream_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  logic        clk,
  input  logic        stall,
  input  logic [33:0] X,
  input  logic [33:0] Y,
  output logic [33:0] R
);

  function automatic logic [33:0] round_pack(input logic sgn, input logic signed [9:0] exp_in,
                                             input logic [22:0] frac, input logic guard,
                                             input logic sticky);
    logic [23:0]       fr;
    logic signed [9:0] e;
    fr = {1'b0, frac} + {23'd0, guard & (sticky | frac[0])};
    e  = exp_in + $signed({9'd0, fr[23]});
    if (e >= 10'sd255)    return {EXC_INF, sgn, 31'd0};
    else if (e <= 10'sd0) return {EXC_ZERO, sgn, 31'd0};
    else                  return {EXC_NORMAL, sgn, e[7:0], fr[22:0]};
  endfunction

  function automatic logic [33:0] fp_mul(input logic [33:0] a, input logic [33:0] b);
    logic              sgn;
    logic [47:0]       prod;
    logic signed [9:0] e;
    sgn = a[31] ^ b[31];
    if (a[33:32] == EXC_NAN || b[33:32] == EXC_NAN ||
        (a[33:32] == EXC_INF && b[33:32] == EXC_ZERO) ||
        (a[33:32] == EXC_ZERO && b[33:32] == EXC_INF))
      return {EXC_NAN, sgn, 31'd0};
    if (a[33:32] == EXC_INF || b[33:32] == EXC_INF)   return {EXC_INF, sgn, 31'd0};
    if (a[33:32] == EXC_ZERO || b[33:32] == EXC_ZERO) return {EXC_ZERO, sgn, 31'd0};
    prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (prod[47]) return round_pack(sgn, e + 10'sd1, prod[46:24], prod[23], |prod[22:0]);
    else          return round_pack(sgn, e, prod[45:23], prod[22], |prod[21:0]);
  endfunction

  logic [33:0] res_p [STAGES];

  // stage 0 computes the full product; later stages only carry it forward
  always_ff @(posedge clk) begin
    if (!stall) begin
      res_p[0] <= fp_mul(X, Y);
      for (int i = 1; i < STAGES; i++) res_p[i] <= res_p[i-1];
    end
  end

  assign R = res_p[STAGES-1];

endmodule

// File: rtl/tybec_sync_fifo.sv
// Show-ahead synchronous FIFO with any depth >= 2; a write while full is
// accepted when a pop frees a slot on the same edge.
module tybec_sync_fifo
  import tybec_stream_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [cnt_w(DEPTH)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == cnt_w(DEPTH)'(DEPTH));
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_ok) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {{(cnt_w(DEPTH)-1){1'b0}}, wr_ok} - {{(cnt_w(DEPTH)-1){1'b0}}, rd_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/coriolis_map_fpmul_credit.sv
// Streaming FloPoCo multiply map node: stall-free core feeding a result FIFO,
// admission limited by a credit counter covering FIFO plus in-flight results.
module coriolis_map_fpmul_credit
  import tybec_stream_pkg::*;
#(
  parameter int                 STREAMW    = 34,
  parameter int                 LAT        = 3,
  parameter int                 FIFO_DEPTH = 5,
  parameter int                 CONST_MODE = 0,
  parameter logic [STREAMW-1:0] CONST_VAL  = {2'b01, 32'h3f800000}
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ivalid_in1_s0,
  input  logic [STREAMW-1:0]               in1_s0,
  input  logic                             ivalid_in2_s0,
  input  logic [STREAMW-1:0]               in2_s0,
  output logic                             iready,
  output logic                             ovalid,
  output logic [STREAMW-1:0]               out1_s0,
  input  logic                             oready,
  output logic [cnt_w(FIFO_DEPTH)-1:0]     occupancy
);

  localparam int OCC_W = cnt_w(FIFO_DEPTH);

  if (LAT < 1) begin : g_lat_chk
    $error("LAT must be at least 1");
  end
  if (FIFO_DEPTH < LAT + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least LAT+1");
  end
  if (STREAMW != 34) begin : g_width_chk
    $error("STREAMW must be 34 for the 8/23 multiplier core");
  end

  logic               ivalid_all, acc, pop, wr_en;
  logic               fifo_empty, fifo_full;
  logic [STREAMW-1:0] op2, core_r;
  logic [LAT-1:0]     vld_sr;
  logic [OCC_W-1:0]   occ_q, fifo_cnt;

  assign ivalid_all = ivalid_in1_s0 & ((CONST_MODE != 0) ? 1'b1 : ivalid_in2_s0);
  assign op2        = (CONST_MODE != 0) ? CONST_VAL : in2_s0;
  assign iready     = (occ_q < OCC_W'(FIFO_DEPTH));
  assign acc        = ivalid_all & iready;
  assign ovalid     = !fifo_empty;
  assign pop        = ovalid & oready;
  assign wr_en      = vld_sr[LAT-1];
  assign occupancy  = occ_q;

  FPMult_8_23_8_23_8_23_F400_uid2 #(
    .STAGES(LAT)
  ) u_core (
    .clk  (clk),
    .stall(1'b0),
    .X    (in1_s0),
    .Y    (op2),
    .R    (core_r)
  );

  // valid tracks the core pipeline one-for-one; credit counts acc minus pop
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
      occ_q  <= '0;
    end else begin
      vld_sr <= LAT'({vld_sr, acc});
      case ({acc, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  tybec_sync_fifo #(
    .WIDTH(STREAMW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(core_r),
    .rd_en  (pop),
    .rd_data(out1_s0),
    .empty  (fifo_empty),
    .full   (fifo_full),
    .count  (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && fifo_full && !pop));
  a_credit_covers_fifo: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= occ_q);

endmodule
